// File: rtl/ex_mem_stage_reg_if.sv
// EX/MEM stage bus: EX-side controls and data in, registered MEM-side copies out.
// The master modport is the EX/driver view, the slave modport is the stage register view.
interface ex_mem_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              stall;
  logic              flush;
  logic              in_valid;
  logic              RegWrite;
  logic              MemtoReg;
  logic              Jump;
  logic              MemWrite;
  logic              MemRead;
  logic              Branch;
  logic              zflag;
  logic [DATA_W-1:0] JumpV;
  logic [DATA_W-1:0] OutBranch;
  logic [DATA_W-1:0] AluRes;
  logic [DATA_W-1:0] Data2;
  logic [REG_W-1:0]  writeReg;

  logic              sal_RegWrite;
  logic              sal_MemtoReg;
  logic              sal_Jump;
  logic              sal_MemWrite;
  logic              sal_MemRead;
  logic              sal_Branch;
  logic              sal_zflag;
  logic [DATA_W-1:0] sal_JumpV;
  logic [DATA_W-1:0] sal_OutBranch;
  logic [DATA_W-1:0] sal_AluRes;
  logic [DATA_W-1:0] sal_Data2;
  logic [REG_W-1:0]  sal_writeReg;
  logic              sal_valid;
  logic              sal_PCSrc;

  modport master (
    output stall, flush, in_valid,
    output RegWrite, MemtoReg, Jump, MemWrite, MemRead, Branch, zflag,
    output JumpV, OutBranch, AluRes, Data2, writeReg,
    input  sal_RegWrite, sal_MemtoReg, sal_Jump, sal_MemWrite, sal_MemRead, sal_Branch,
    input  sal_zflag, sal_JumpV, sal_OutBranch, sal_AluRes, sal_Data2, sal_writeReg,
    input  sal_valid, sal_PCSrc
  );

  modport slave (
    input  stall, flush, in_valid,
    input  RegWrite, MemtoReg, Jump, MemWrite, MemRead, Branch, zflag,
    input  JumpV, OutBranch, AluRes, Data2, writeReg,
    output sal_RegWrite, sal_MemtoReg, sal_Jump, sal_MemWrite, sal_MemRead, sal_Branch,
    output sal_zflag, sal_JumpV, sal_OutBranch, sal_AluRes, sal_Data2, sal_writeReg,
    output sal_valid, sal_PCSrc
  );
endinterface

// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline register with sync reset, stall, flush and valid-gated controls.
// Define EXMEM_PERF_EN to add saturating stall_cnt / flush_cnt performance counters.
module ex_mem_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  ex_mem_stage_reg_if.slave   bus
`ifdef EXMEM_PERF_EN
  ,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
`endif
);

  logic              r_regWrite;
  logic              r_memtoReg;
  logic              r_jump;
  logic              r_memWrite;
  logic              r_memRead;
  logic              r_branch;
  logic              r_zflag;
  logic [DATA_W-1:0] r_jumpV;
  logic [DATA_W-1:0] r_outBranch;
  logic [DATA_W-1:0] r_aluRes;
  logic [DATA_W-1:0] r_data2;
  logic [REG_W-1:0]  r_writeReg;
  logic              r_valid;
  logic              r_pcSrc;

  logic              w_clear;
  logic              w_load;

  // Reset and flush both empty the stage; stall simply skips the load.
  assign w_clear = rst | bus.flush;
  assign w_load  = ~w_clear & ~bus.stall;

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_regWrite  <= 1'b0;
      r_memtoReg  <= 1'b0;
      r_jump      <= 1'b0;
      r_memWrite  <= 1'b0;
      r_memRead   <= 1'b0;
      r_branch    <= 1'b0;
      r_zflag     <= 1'b0;
      r_jumpV     <= '0;
      r_outBranch <= '0;
      r_aluRes    <= '0;
      r_data2     <= '0;
      r_writeReg  <= '0;
      r_valid     <= 1'b0;
      r_pcSrc     <= 1'b0;
    end else if (w_load) begin
      r_regWrite  <= bus.RegWrite & bus.in_valid;
      r_memtoReg  <= bus.MemtoReg & bus.in_valid;
      r_jump      <= bus.Jump     & bus.in_valid;
      r_memWrite  <= bus.MemWrite & bus.in_valid;
      r_memRead   <= bus.MemRead  & bus.in_valid;
      r_branch    <= bus.Branch   & bus.in_valid;
      r_zflag     <= bus.zflag;
      r_jumpV     <= bus.JumpV;
      r_outBranch <= bus.OutBranch;
      r_aluRes    <= bus.AluRes;
      r_data2     <= bus.Data2;
      r_writeReg  <= bus.writeReg;
      r_valid     <= bus.in_valid;
      r_pcSrc     <= bus.Branch & bus.zflag & bus.in_valid;
    end
  end

  assign bus.sal_RegWrite  = r_regWrite;
  assign bus.sal_MemtoReg  = r_memtoReg;
  assign bus.sal_Jump      = r_jump;
  assign bus.sal_MemWrite  = r_memWrite;
  assign bus.sal_MemRead   = r_memRead;
  assign bus.sal_Branch    = r_branch;
  assign bus.sal_zflag     = r_zflag;
  assign bus.sal_JumpV     = r_jumpV;
  assign bus.sal_OutBranch = r_outBranch;
  assign bus.sal_AluRes    = r_aluRes;
  assign bus.sal_Data2     = r_data2;
  assign bus.sal_writeReg  = r_writeReg;
  assign bus.sal_valid     = r_valid;
  assign bus.sal_PCSrc     = r_pcSrc;

`ifdef EXMEM_PERF_EN
  logic [CNT_W-1:0] r_stallCnt;
  logic [CNT_W-1:0] r_flushCnt;
  logic [CNT_W-1:0] w_one;

  assign w_one = {{(CNT_W-1){1'b0}}, 1'b1};

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stallCnt <= '0;
      r_flushCnt <= '0;
    end else if (bus.flush) begin
      if (r_flushCnt != {CNT_W{1'b1}}) r_flushCnt <= r_flushCnt + w_one;
    end else if (bus.stall) begin
      if (r_stallCnt != {CNT_W{1'b1}}) r_stallCnt <= r_stallCnt + w_one;
    end
  end

  assign stall_cnt = r_stallCnt;
  assign flush_cnt = r_flushCnt;
`endif

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Self-checking bench for ex_mem_stage_reg: directed plan steps plus random traffic vs a model.
// Counter checks are active when EXMEM_PERF_EN is defined (CNT_W=4 here).
module tb_ex_mem_stage_reg;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic        valid;
    logic        pcSrc;
    logic        regWrite;
    logic        memtoReg;
    logic        jump;
    logic        memWrite;
    logic        memRead;
    logic        branch;
    logic        zflag;
    logic [31:0] jumpV;
    logic [31:0] outBranch;
    logic [31:0] aluRes;
    logic [31:0] data2;
    logic [4:0]  writeReg;
  } stage_t;

  logic   clk = 1'b0;
  logic   rst;
  stage_t expStage;
  int     expStallCnt;
  int     expFlushCnt;
  int     checks = 0;
  int     errors = 0;

  ex_mem_stage_reg_if #(.DATA_W(DATA_W), .REG_W(REG_W)) bus ();

`ifdef EXMEM_PERF_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  ex_mem_stage_reg #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
`else
  ex_mem_stage_reg #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
`endif

  always #5 clk = ~clk;

  task automatic checkField(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clearInputs();
    bus.stall = 0; bus.flush = 0; bus.in_valid = 0;
    bus.RegWrite = 0; bus.MemtoReg = 0; bus.Jump = 0; bus.MemWrite = 0;
    bus.MemRead = 0; bus.Branch = 0; bus.zflag = 0;
    bus.JumpV = '0; bus.OutBranch = '0; bus.AluRes = '0; bus.Data2 = '0; bus.writeReg = '0;
  endtask

  // Reference: what the MEM stage should hold after one edge with the current inputs.
  task automatic stepModel();
    stage_t nxt;
    nxt = expStage;
    if (rst || bus.flush) begin
      nxt = '0;
    end else if (!bus.stall) begin
      nxt.valid     = bus.in_valid;
      nxt.regWrite  = bus.in_valid ? bus.RegWrite : 1'b0;
      nxt.memtoReg  = bus.in_valid ? bus.MemtoReg : 1'b0;
      nxt.jump      = bus.in_valid ? bus.Jump     : 1'b0;
      nxt.memWrite  = bus.in_valid ? bus.MemWrite : 1'b0;
      nxt.memRead   = bus.in_valid ? bus.MemRead  : 1'b0;
      nxt.branch    = bus.in_valid ? bus.Branch   : 1'b0;
      nxt.pcSrc     = (bus.in_valid && bus.Branch && bus.zflag);
      nxt.zflag     = bus.zflag;
      nxt.jumpV     = bus.JumpV;
      nxt.outBranch = bus.OutBranch;
      nxt.aluRes    = bus.AluRes;
      nxt.data2     = bus.Data2;
      nxt.writeReg  = bus.writeReg;
    end
    expStage = nxt;
    if (rst) begin
      expStallCnt = 0;
      expFlushCnt = 0;
    end else if (bus.flush) begin
      expFlushCnt = (expFlushCnt < CNT_MAX) ? expFlushCnt + 1 : CNT_MAX;
    end else if (bus.stall) begin
      expStallCnt = (expStallCnt < CNT_MAX) ? expStallCnt + 1 : CNT_MAX;
    end
  endtask

  task automatic checkOutput(input string tag);
    checkField({tag, "_valid"},     32'(bus.sal_valid),    32'(expStage.valid));
    checkField({tag, "_PCSrc"},     32'(bus.sal_PCSrc),    32'(expStage.pcSrc));
    checkField({tag, "_RegWrite"},  32'(bus.sal_RegWrite), 32'(expStage.regWrite));
    checkField({tag, "_MemtoReg"},  32'(bus.sal_MemtoReg), 32'(expStage.memtoReg));
    checkField({tag, "_Jump"},      32'(bus.sal_Jump),     32'(expStage.jump));
    checkField({tag, "_MemWrite"},  32'(bus.sal_MemWrite), 32'(expStage.memWrite));
    checkField({tag, "_MemRead"},   32'(bus.sal_MemRead),  32'(expStage.memRead));
    checkField({tag, "_Branch"},    32'(bus.sal_Branch),   32'(expStage.branch));
    checkField({tag, "_zflag"},     32'(bus.sal_zflag),    32'(expStage.zflag));
    checkField({tag, "_JumpV"},     bus.sal_JumpV,         expStage.jumpV);
    checkField({tag, "_OutBranch"}, bus.sal_OutBranch,     expStage.outBranch);
    checkField({tag, "_AluRes"},    bus.sal_AluRes,        expStage.aluRes);
    checkField({tag, "_Data2"},     bus.sal_Data2,         expStage.data2);
    checkField({tag, "_writeReg"},  32'(bus.sal_writeReg), 32'(expStage.writeReg));
    if (!bus.sal_valid)
      checkField({tag, "_invariant"},
                 32'({bus.sal_RegWrite, bus.sal_MemWrite, bus.sal_MemRead,
                      bus.sal_Jump, bus.sal_Branch, bus.sal_PCSrc}), 32'd0);
`ifdef EXMEM_PERF_EN
    checkField({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(expStallCnt));
    checkField({tag, "_flush_cnt"}, 32'(flush_cnt), 32'(expFlushCnt));
`endif
  endtask

  task automatic applyStimulus(input string tag);
    @(posedge clk);
    stepModel();
    #1;
    checkOutput(tag);
  endtask

  initial begin
    expStage = '0;
    expStallCnt = 0;
    expFlushCnt = 0;
    clearInputs();
    rst = 1'b1;
    #1;

    // Reset with every input forced high.
    bus.stall = 1; bus.flush = 1; bus.in_valid = 1;
    bus.RegWrite = 1; bus.MemtoReg = 1; bus.Jump = 1; bus.MemWrite = 1;
    bus.MemRead = 1; bus.Branch = 1; bus.zflag = 1;
    bus.JumpV = '1; bus.OutBranch = '1; bus.AluRes = '1; bus.Data2 = '1; bus.writeReg = '1;
    applyStimulus("reset1");
    applyStimulus("reset2");
    checkField("reset_AluRes_zero", bus.sal_AluRes, 32'h0);
    checkField("reset_valid_zero", 32'(bus.sal_valid), 32'd0);

    rst = 0; bus.stall = 0; bus.flush = 0;
    applyStimulus("post_reset_load");
    checkField("post_reset_PCSrc", 32'(bus.sal_PCSrc), 32'd1);

    clearInputs();
    bus.in_valid = 1; bus.RegWrite = 1; bus.MemRead = 1;
    bus.AluRes = 32'h0000_1234; bus.writeReg = 5'd9;
    applyStimulus("load");
    checkField("load_AluRes_const", bus.sal_AluRes, 32'h0000_1234);
    checkField("load_writeReg_const", 32'(bus.sal_writeReg), 32'd9);

    clearInputs();
    bus.in_valid = 1; bus.Branch = 1; bus.zflag = 1; bus.OutBranch = 32'h0040_0020;
    applyStimulus("branch_taken");
    checkField("branch_taken_PCSrc", 32'(bus.sal_PCSrc), 32'd1);
    bus.zflag = 0;
    applyStimulus("branch_nz");
    checkField("branch_nz_PCSrc", 32'(bus.sal_PCSrc), 32'd0);
    bus.zflag = 1; bus.in_valid = 0;
    applyStimulus("branch_invalid");
    checkField("branch_invalid_Branch", 32'(bus.sal_Branch), 32'd0);

    clearInputs();
    bus.in_valid = 1; bus.AluRes = 32'hDEAD_BEEF;
    applyStimulus("stall_load");
    bus.stall = 1; bus.AluRes = 32'h1; bus.Data2 = 32'h1; bus.JumpV = 32'h1;
    for (int i = 0; i < 3; i++) applyStimulus("stall_hold");
    checkField("stall_hold_AluRes", bus.sal_AluRes, 32'hDEAD_BEEF);
    bus.stall = 0;
    applyStimulus("stall_release");
    checkField("stall_release_AluRes", bus.sal_AluRes, 32'h1);

    clearInputs();
    bus.in_valid = 1; bus.MemWrite = 1; bus.Data2 = 32'hCAFE_0001; bus.AluRes = 32'h44;
    applyStimulus("flush_preload");
    bus.stall = 1; bus.flush = 1;
    applyStimulus("flush_over_stall");
    checkField("flush_MemWrite", 32'(bus.sal_MemWrite), 32'd0);
    checkField("flush_Data2", bus.sal_Data2, 32'h0);

    // Reset during a stall, then a stall after reset keeps the zeros.
    clearInputs();
    bus.in_valid = 1; bus.RegWrite = 1; bus.AluRes = 32'h77;
    applyStimulus("midstall_load");
    bus.stall = 1; rst = 1;
    applyStimulus("midstall_reset");
    rst = 0;
    applyStimulus("midstall_hold");

    for (int i = 0; i < 300; i++) begin
      rst          = ($urandom_range(0, 24) == 0);
      bus.flush    = ($urandom_range(0, 7) == 0);
      bus.stall    = ($urandom_range(0, 3) == 0);
      bus.in_valid = $urandom_range(0, 1);
      bus.RegWrite = $urandom_range(0, 1);
      bus.MemtoReg = $urandom_range(0, 1);
      bus.Jump     = $urandom_range(0, 1);
      bus.MemWrite = $urandom_range(0, 1);
      bus.MemRead  = $urandom_range(0, 1);
      bus.Branch   = $urandom_range(0, 1);
      bus.zflag    = $urandom_range(0, 1);
      bus.JumpV    = $urandom;
      bus.OutBranch = $urandom;
      bus.AluRes   = $urandom;
      bus.Data2    = $urandom;
      bus.writeReg = 5'($urandom);
      applyStimulus("random");
    end

`ifdef EXMEM_PERF_EN
    clearInputs();
    rst = 1;
    applyStimulus("perf_reset");
    rst = 0; bus.stall = 1;
    for (int i = 0; i < 20; i++) applyStimulus("perf_stall");
    checkField("perf_stall_sat", 32'(stall_cnt), 32'd15);
    bus.stall = 0; bus.flush = 1;
    for (int i = 0; i < 3; i++) applyStimulus("perf_flush");
    checkField("perf_flush_three", 32'(flush_cnt), 32'd3);
    bus.flush = 0; rst = 1;
    applyStimulus("perf_clear");
    checkField("perf_clear_stall", 32'(stall_cnt), 32'd0);
    checkField("perf_clear_flush", 32'(flush_cnt), 32'd0);
    rst = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
